// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA 640x480@60 Hz pixel-timing generator. Sits directly behind the
//   50->25 MHz PLL wrapper. It is clocked by the PLL's 25 MHz output and
//   held idle until the PLL lock indication has been synchronised and seen
//   stable for LOCK_STABLE consecutive cycles. It falls back to idle as soon
//   as the synchronised lock drops.
//
//   Ports
//     refclk       in   25 MHz pixel clock (PLL outclk_0)
//     rst          in   synchronous reset, active-high
//     pll_locked   in   PLL locked, asynchronous to refclk
//     hsync/vsync  out  sync pulses, level set by SYNC_POL
//     de           out  display enable (visible region)
//     px_x/px_y    out  pixel coordinates, 0 outside the visible region
//     line_start   out  one-cycle pulse at the first clock of every line
//     frame_start  out  one-cycle pulse at the first clock of every frame
//     running      out  high while the timing generator is running
//     r/g/b        out  4-bit colour-bar test pattern (only with macro)
//
//   Optional feature: define VGA_TEST_PATTERN_EN to add the r/g/b outputs
//   carrying an 8-bar colour test pattern.
//
//   All outputs are registered one cycle behind the h/v counters.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_STABLE = 16,
  parameter int CW          = 10
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LKW     = $clog2(LOCK_STABLE + 1);

  localparam logic [LKW-1:0] LK_MAX = LKW'(LOCK_STABLE);
  localparam logic [CW-1:0]  H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]  HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0]  VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]  VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0]  H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]  V_VIS  = CW'(V_ACTIVE);
  localparam bit             IDLE_SYNC = ~SYNC_POL;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           sync_q1, sync_q2;
  logic [LKW-1:0] lk_cnt_q, lk_cnt_d;
  logic [CW-1:0]  h_cnt_q, h_cnt_d;
  logic [CW-1:0]  v_cnt_q, v_cnt_d;

  logic           hs_act, vs_act, vis, h_wrap, v_wrap, run;

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [CW-1:0]  px_x_q, px_x_d;
  logic [CW-1:0]  px_y_q, px_y_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           running_q, running_d;

`ifdef VGA_TEST_PATTERN_EN
  logic [3:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic [2:0]     colour;

  // Eight equal-width bars across the active line; bar 0 (leftmost) is
  // white, so the RGB bit pattern is simply 7 - bar.
  function automatic logic [2:0] bar_colour(input logic [CW-1:0] h);
    logic [2:0] bar;
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h >= CW'(k * (H_ACTIVE / 8))) bar = 3'(k);
    end
    return 3'd7 - bar;
  endfunction
`endif

  // Decode of the current counter values; registered below.
  always_comb begin
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);
    hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
    vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
    vis    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    run    = (state_q == RUN);
  end

  // Stable-lock counter: any synchronised low restarts the count.
  always_comb begin
    lk_cnt_d = lk_cnt_q;
    if (!sync_q2) begin
      lk_cnt_d = '0;
    end else if (lk_cnt_q != LK_MAX) begin
      lk_cnt_d = lk_cnt_q + LKW'(1);
    end
  end

  // Next state and raster counters. Counters are held at zero outside RUN,
  // so the first RUN cycle always starts a fresh frame.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if ((lk_cnt_q == LK_MAX) && sync_q2) state_d = RUN;
      end
      RUN: begin
        if (!sync_q2) begin
          // Lock lost: abandon the partial frame immediately.
          state_d = WAIT_LOCK;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else if (h_wrap) begin
          h_cnt_d = '0;
          v_cnt_d = v_wrap ? '0 : v_cnt_q + CW'(1);
        end else begin
          h_cnt_d = h_cnt_q + CW'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output next values; outside RUN everything collapses to the idle pattern.
  always_comb begin
    hsync_d       = (run && hs_act) ? SYNC_POL : IDLE_SYNC;
    vsync_d       = (run && vs_act) ? SYNC_POL : IDLE_SYNC;
    de_d          = run && vis;
    px_x_d        = (run && vis) ? h_cnt_q : '0;
    px_y_d        = (run && vis) ? v_cnt_q : '0;
    line_start_d  = run && (h_cnt_q == '0);
    frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);
    running_d     = run;
`ifdef VGA_TEST_PATTERN_EN
    colour = bar_colour(h_cnt_q);
    r_d    = (run && vis && colour[2]) ? 4'hF : 4'h0;
    g_d    = (run && vis && colour[1]) ? 4'hF : 4'h0;
    b_d    = (run && vis && colour[0]) ? 4'hF : 4'h0;
`endif
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      lk_cnt_q      <= '0;
      state_q       <= WAIT_LOCK;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= IDLE_SYNC;
      vsync_q       <= IDLE_SYNC;
      de_q          <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      r_q           <= 4'h0;
      g_q           <= 4'h0;
      b_q           <= 4'h0;
`endif
    end else begin
      // Two-flop synchroniser for the asynchronous lock input.
      sync_q1       <= pll_locked;
      sync_q2       <= sync_q1;
      lk_cnt_q      <= lk_cnt_d;
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
`ifdef VGA_TEST_PATTERN_EN
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;
`ifdef VGA_TEST_PATTERN_EN
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Horizontal timing uses the real 640x480
// values; the frame is shortened vertically (16 lines) so that two complete
// frames fit in a short run. The reference model describes the expected
// outputs as a function of how long the (reset-free) lock input has been
// continuously high, independent of the design's internal structure.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int LS       = 16;
  localparam int CW       = 10;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int START_LAT = 2 + LS + 2;
`ifdef VGA_TEST_PATTERN_EN
  localparam int VW = 2 * CW + 6 + 12;
`else
  localparam int VW = 2 * CW + 6;
`endif

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          hsync, vsync, de, line_start, frame_start, running;
  logic [CW-1:0] px_x, px_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [3:0]    r, g, b;
`endif
  logic [VW-1:0] obs;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .LOCK_STABLE(LS), .CW(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .px_x(px_x), .px_y(px_y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef VGA_TEST_PATTERN_EN
    , .r(r), .g(g), .b(b)
`endif
  );

`ifdef VGA_TEST_PATTERN_EN
  assign obs = {hsync, vsync, de, px_x, px_y, line_start, frame_start, running, r, g, b};
`else
  assign obs = {hsync, vsync, de, px_x, px_y, line_start, frame_start, running};
`endif

  initial forever #5 refclk = ~refclk;

  int checks = 0;
  int failures = 0;
  int ticks = 0;
  // lh[k]: length of the run of (rst=0, lock=1) samples ending k edges ago.
  int lh[4] = '{0, 0, 0, 0};
  bit rh[3] = '{1'b1, 1'b1, 1'b1};

  // Expected output word: idle, or position n (clocks since the first
  // running cycle) within the free-running raster.
  function automatic logic [VW-1:0] model_vec(input bit act, input int n);
    int h, v;
    logic hs_o, vs_o, de_o, ls_o, fs_o;
    logic [CW-1:0] x_o, y_o;
    logic [2:0] col;
    logic [2*CW+5:0] base;
    hs_o = 1'b1; vs_o = 1'b1; de_o = 1'b0; ls_o = 1'b0; fs_o = 1'b0;
    x_o = '0; y_o = '0; col = 3'd0;
    if (act) begin
      h = n % H_TOTAL;
      v = (n / H_TOTAL) % V_TOTAL;
      hs_o = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      vs_o = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
      de_o = (h < H_ACTIVE) && (v < V_ACTIVE);
      if (de_o) begin
        x_o = CW'(h);
        y_o = CW'(v);
        col = 3'(7 - h / (H_ACTIVE / 8));
      end
      ls_o = (h == 0);
      fs_o = (h == 0) && (v == 0);
    end
    base = {hs_o, vs_o, de_o, x_o, y_o, ls_o, fs_o, act};
`ifdef VGA_TEST_PATTERN_EN
    return {base, (col[2] ? 4'hF : 4'h0), (col[1] ? 4'hF : 4'h0), (col[0] ? 4'hF : 4'h0)};
`else
    if (col != 3'd0) return base;
    return base;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock: drive inputs, advance, update the model, compare everything.
  task automatic tick(input logic r_i, input logic p_i);
    int newl;
    bit act;
    logic [VW-1:0] exp_v;
    rst = r_i;
    pll_locked = p_i;
    @(posedge refclk);
    #1;
    ticks++;
    newl = (!r_i && p_i) ? lh[0] + 1 : 0;
    lh[3] = lh[2]; lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = newl;
    rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = r_i;
    act = !rh[0] && !rh[1] && !rh[2] && (lh[3] >= LS + 1);
    exp_v = model_vec(act, lh[3] - LS - 1);
    if (failures < 40) begin
      checks++;
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL model tick=%0d observed=%h expected=%h", ticks, obs, exp_v);
      end
    end
  endtask

  initial begin
    int first, idle_at, g_len, d_line, h_pos, len;
    int hs_low, vs_low, de_hi, nfs, fs_period, last_fs, last_ls, ls_tick;
    int bad_ls, bad_hs_off, last_px;
    logic prev_hs, p;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb0, rgb85, rgb639;
    int rgb_blank_bad;
    rgb0 = 12'hABC; rgb85 = 12'hABC; rgb639 = 12'hABC; rgb_blank_bad = 0;
`endif

    // Reset with lock held high, then time the start-up.
    repeat (3) tick(1'b1, 1'b1);
    check("reset_running", running, 0);
    check("reset_hsync", hsync, 1);
    first = 0;
    for (int i = 1; i <= 60 && first == 0; i++) begin
      tick(1'b0, 1'b1);
      if (running === 1'b1) first = i;
    end
    check("lock_to_running", first, START_LAT);
    check("first_frame_start", frame_start, 1);
    check("first_line_start", line_start, 1);
    check("first_de", de, 1);
    check("first_px", {px_x, px_y}, 0);

    // Two complete frames of free running with raster measurements.
    hs_low = 0; vs_low = 0; de_hi = 0; nfs = 0; fs_period = 0; last_fs = 0;
    last_ls = 0; ls_tick = 0; bad_ls = 0; bad_hs_off = 0; last_px = 0;
    prev_hs = 1'b1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      tick(1'b0, 1'b1);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_hi++;
      if (frame_start) begin
        fs_period = i - last_fs;
        last_fs = i;
        nfs++;
      end
      if (line_start) begin
        if (i - last_ls != H_TOTAL) bad_ls++;
        last_ls = i;
        ls_tick = i;
      end
      if (!hsync && prev_hs && (i - ls_tick != H_ACTIVE + H_FP)) bad_hs_off++;
      prev_hs = hsync;
      if (de && px_x == 10'(H_ACTIVE - 1) && px_y == 10'(V_ACTIVE - 1)) last_px++;
`ifdef VGA_TEST_PATTERN_EN
      if (de && px_x == 10'd0) rgb0 = {r, g, b};
      if (de && px_x == 10'd85) rgb85 = {r, g, b};
      if (de && px_x == 10'd639) rgb639 = {r, g, b};
      if (!de && {r, g, b} != 12'h000) rgb_blank_bad++;
`endif
    end
    check("hsync_low_cycles", hs_low, 2 * V_TOTAL * H_SYNC);
    check("vsync_low_cycles", vs_low, 2 * V_SYNC * H_TOTAL);
    check("de_high_cycles", de_hi, 2 * V_ACTIVE * H_ACTIVE);
    check("frame_start_count", nfs, 2);
    check("frame_start_period", fs_period, FRAME);
    check("line_start_period_errors", bad_ls, 0);
    check("hsync_offset_errors", bad_hs_off, 0);
    check("last_visible_pixel", last_px, 2);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x0", rgb0, 12'hFFF);
    check("rgb_x85", rgb85, 12'hFF0);
    check("rgb_x639", rgb639, 12'h000);
    check("rgb_blanking", rgb_blank_bad, 0);
`endif

    // One-cycle lock glitch while waiting for lock restarts the count.
    repeat (2) tick(1'b1, 1'b1);
    g_len = $urandom_range(6, 14);
    repeat (g_len) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    first = 0;
    for (int i = 1; i <= 60 && first == 0; i++) begin
      tick(1'b0, 1'b1);
      if (running === 1'b1) first = i;
    end
    check("glitch_restart", first, START_LAT);

    // Lose lock mid-frame, then re-lock.
    d_line = $urandom_range(2, V_TOTAL - 2);
    h_pos = $urandom_range(0, H_TOTAL - 1);
    repeat (d_line * H_TOTAL + h_pos) tick(1'b0, 1'b1);
    idle_at = 0;
    for (int i = 1; i <= 10 && idle_at == 0; i++) begin
      tick(1'b0, 1'b0);
      if (!running && !de && hsync && vsync && !line_start && !frame_start) idle_at = i;
    end
    check("drop_idle_within4", (idle_at >= 1 && idle_at <= 4), 1);
    repeat ($urandom_range(0, 6)) tick(1'b0, 1'b0);
    first = 0;
    for (int i = 1; i <= 60 && first == 0; i++) begin
      tick(1'b0, 1'b1);
      if (running === 1'b1) first = i;
    end
    check("relock_latency", first, START_LAT);
    check("relock_frame_start", frame_start, 1);
    check("relock_px_y", px_y, 0);

    // Reset mid-frame with lock still high.
    repeat ($urandom_range(100, 3000)) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("midframe_rst_running", running, 0);
    check("midframe_rst_de", de, 0);
    check("midframe_rst_vsync", vsync, 1);

    // Random lock/reset segments against the model.
    for (int s = 0; s < 40; s++) begin
      p = ($urandom_range(0, 3) != 0);
      len = p ? $urandom_range(5, 400) : $urandom_range(1, 6);
      tick(($urandom_range(0, 19) == 0), p);
      repeat (len - 1) tick(1'b0, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
